// File: rtl/redun_sq_loop_ctrl.sv
// Iteration controller for the redundant Montgomery squarer: feeds the core its own
// output T times and emits checkpoints plus the final value through a small show-ahead FIFO.
`timescale 1ns/1ps
module redun_sq_loop_ctrl #(
  parameter int NUM_WRDS  = 64,
  parameter int WRD_BITS  = 16,
  parameter int ITER_W    = 32,
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 1024,
  localparam int DW = NUM_WRDS * WRD_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DW-1:0]     i_in_dat,
  input  logic [ITER_W-1:0] i_in_iter,
  input  logic [ITER_W-1:0] i_in_snap,
  input  logic              i_in_val,
  output logic              o_in_rdy,
  input  logic              i_abort,
  output logic [DW-1:0]     o_core_sq,
  output logic              o_core_val,
  input  logic [DW-1:0]     i_core_mul,
  input  logic              i_core_val,
  output logic [DW-1:0]     o_out_dat,
  output logic [ITER_W-1:0] o_out_iter,
  output logic              o_out_last,
  output logic              o_out_val,
  input  logic              i_out_rdy,
  output logic              o_busy,
  output logic              o_err
);
  localparam int EW  = DW + ITER_W + 1;
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, STALL, DRAIN} state_t;

  state_t            state;
  logic [DW-1:0]     cur;
  logic [ITER_W-1:0] t_val, k_val, cnt, snap_cnt;
  logic [WDW-1:0]    wdog;
  logic              err, core_val;

  logic [EW-1:0]     mem [OUT_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]     count, count_after_pop, count_next;
  logic [EW-1:0]     push_entry, head_next;
  logic              pop, push, space, wdog_expired;
  logic [ITER_W-1:0] cnt_inc, snap_inc;
  logic              snap_hit, iter_done;

  assign cnt_inc      = cnt + 1'b1;
  assign snap_inc     = snap_cnt + 1'b1;
  assign snap_hit     = (k_val != '0) && (snap_inc == k_val);
  assign iter_done    = (cnt_inc == t_val);
  assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

  assign pop             = o_out_val & i_out_rdy;
  assign space           = (count < CW'(OUT_DEPTH)) || pop;
  assign push            = (state == PUSH || state == STALL) && !i_abort && space;
  assign push_entry      = {cur, cnt, (cnt == t_val)};
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);
  assign rd_ptr_next     = rd_ptr + PW'(pop);
  // An entry written into an otherwise empty FIFO goes straight to the output registers.
  assign head_next       = (push && count_after_pop == '0) ? push_entry : mem[rd_ptr_next];

  assign o_in_rdy   = (state == IDLE) && !i_abort;
  assign o_core_sq  = cur;
  assign o_core_val = core_val;
  assign o_busy     = (state != IDLE);
  assign o_err      = err;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_out_val  <= 1'b0;
      o_out_dat  <= '0;
      o_out_iter <= '0;
      o_out_last <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      o_out_val <= (count_next != '0);
      if (count_next != '0) {o_out_dat, o_out_iter, o_out_last} <= head_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cur      <= '0;
      t_val    <= '0;
      k_val    <= '0;
      cnt      <= '0;
      snap_cnt <= '0;
      wdog     <= '0;
      err      <= 1'b0;
      core_val <= 1'b0;
    end else begin
      core_val <= 1'b0;
      if (i_core_val && state != WAIT && state != DRAIN) err <= 1'b1;
      case (state)
        IDLE: begin
          if (i_in_val && !i_abort) begin
            cur      <= i_in_dat;
            t_val    <= i_in_iter;
            k_val    <= i_in_snap;
            cnt      <= '0;
            snap_cnt <= '0;
            if (i_in_iter == '0) begin
              state <= PUSH;
            end else begin
              state    <= ISSUE;
              core_val <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= i_abort ? IDLE : WAIT;
        end
        WAIT: begin
          if (i_core_val) begin
            cur      <= i_core_mul;
            cnt      <= cnt_inc;
            snap_cnt <= snap_hit ? '0 : snap_inc;
            if (i_abort) begin
              state <= IDLE;
            end else if (iter_done || snap_hit) begin
              state <= PUSH;
            end else begin
              state    <= ISSUE;
              core_val <= 1'b1;
            end
          end else if (wdog_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
            if (i_abort) state <= DRAIN;
          end
        end
        PUSH, STALL: begin
          if (i_abort) begin
            state <= IDLE;
          end else if (space) begin
            if (cnt < t_val) begin
              state    <= ISSUE;
              core_val <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= STALL;
          end
        end
        DRAIN: begin
          // The aborted job's response still has to be absorbed before a new job may start.
          if (i_core_val) begin
            state <= IDLE;
          end else if (wdog_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
